// File: rtl/prbs4_checker.sv
`default_nettype none
// ============================================================================
//  Module      : prbs4_checker
//  Description : Receive-side checker for the 4-bit LFSR pattern
//                next = {s[2:0], s[3]^s[0]} (period 15). Self-synchronises
//                to the incoming words, declares lock, then free-runs its
//                own copy of the sequence and counts mismatched words.
//                Lock is dropped after LOSS_CNT consecutive bad words.
//
//  Ports       : clk          rising-edge clock
//                rst_n        asynchronous active-low reset
//                data_in      received PRBS word (4 bits)
//                data_vld     data_in valid; state only advances when high
//                clr_cnt      synchronous clear of both error counters
//                locked       checker is in LOCKED state
//                err_pulse    previous valid word mismatched while locked
//                err_cnt      saturating count of mismatched words
//                bit_err_cnt  saturating count of mismatched bits
//
//  Options     : `define PRBS4_CHK_BITERR_EN to build the bit error counter;
//                without it bit_err_cnt is tied to zero.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs4_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       data_in,
    input  logic             data_vld,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] bit_err_cnt
);

    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_VERIFY = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam logic [3:0]       c_lock_cnt = 4'(LOCK_CNT);
    localparam logic [3:0]       c_loss_cnt = 4'(LOSS_CNT);
    localparam logic [ERR_W-1:0] c_cnt_max  = {ERR_W{1'b1}};

    function automatic logic [3:0] f_next(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[0]};
    endfunction

    logic [1:0]       r_state;
    logic [3:0]       r_expected;
    logic [3:0]       r_match_run;
    logic [3:0]       r_err_run;
    logic             r_locked;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_cnt;

    logic             w_match;
    logic             w_count_err;
    logic [3:0]       w_match_run_inc;
    logic [3:0]       w_err_run_inc;

    assign w_match         = (data_in == r_expected);
    assign w_count_err     = data_vld && (r_state == S_LOCKED) && !w_match;
    assign w_match_run_inc = r_match_run + 4'd1;
    assign w_err_run_inc   = r_err_run + 4'd1;

    // ------------------------------------------------------------------
    // Synchronisation state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_SEARCH;
            r_expected  <= 4'd0;
            r_match_run <= 4'd0;
            r_err_run   <= 4'd0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (data_vld) begin
                case (r_state)
                    S_SEARCH: begin
                        // All-zero is the LFSR lock-up word and can never seed.
                        if (data_in != 4'd0) begin
                            r_expected  <= f_next(data_in);
                            r_match_run <= 4'd0;
                            r_state     <= S_VERIFY;
                        end
                    end
                    S_VERIFY: begin
                        if (w_match) begin
                            r_expected <= f_next(r_expected);
                            if (w_match_run_inc == c_lock_cnt) begin
                                r_state     <= S_LOCKED;
                                r_locked    <= 1'b1;
                                r_match_run <= 4'd0;
                                r_err_run   <= 4'd0;
                            end else begin
                                r_match_run <= w_match_run_inc;
                            end
                        end else if (data_in != 4'd0) begin
                            r_expected  <= f_next(data_in);
                            r_match_run <= 4'd0;
                        end else begin
                            r_state     <= S_SEARCH;
                            r_match_run <= 4'd0;
                        end
                    end
                    S_LOCKED: begin
                        // Free-running: never re-seed from data, so a single
                        // corrupted word costs exactly one error.
                        r_expected <= f_next(r_expected);
                        if (w_match) begin
                            r_err_run <= 4'd0;
                        end else begin
                            r_err_pulse <= 1'b1;
                            if (w_err_run_inc == c_loss_cnt) begin
                                r_state     <= S_SEARCH;
                                r_locked    <= 1'b0;
                                r_err_run   <= 4'd0;
                                r_match_run <= 4'd0;
                            end else begin
                                r_err_run <= w_err_run_inc;
                            end
                        end
                    end
                    default: begin
                        r_state  <= S_SEARCH;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Word error counter (clear wins over increment)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (clr_cnt) begin
            r_err_cnt <= '0;
        end else if (w_count_err && (r_err_cnt != c_cnt_max)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

`ifdef PRBS4_CHK_BITERR_EN
    // ------------------------------------------------------------------
    // Bit error counter: adds popcount of the error word, saturating
    // ------------------------------------------------------------------
    logic [3:0]       w_diff;
    logic [2:0]       w_popcnt;
    logic [ERR_W:0]   w_bit_sum;
    logic [ERR_W-1:0] r_bit_err_cnt;

    assign w_diff    = data_in ^ r_expected;
    assign w_popcnt  = {2'b00, w_diff[0]} + {2'b00, w_diff[1]}
                     + {2'b00, w_diff[2]} + {2'b00, w_diff[3]};
    assign w_bit_sum = {1'b0, r_bit_err_cnt} + (ERR_W+1)'(w_popcnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_err_cnt <= '0;
        end else if (clr_cnt) begin
            r_bit_err_cnt <= '0;
        end else if (w_count_err) begin
            r_bit_err_cnt <= w_bit_sum[ERR_W] ? c_cnt_max : w_bit_sum[ERR_W-1:0];
        end
    end

    assign bit_err_cnt = r_bit_err_cnt;
`else
    assign bit_err_cnt = '0;
`endif

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prbs4_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs4_checker
//  Description : Self-checking bench for prbs4_checker (ERR_W=4, LOCK_CNT=4,
//                LOSS_CNT=3). Directed vector table followed by hand-written
//                saturation and asynchronous reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs4_checker;

    localparam int c_err_w = 4;

`ifdef PRBS4_CHK_BITERR_EN
    localparam bit c_bit_en = 1'b1;
`else
    localparam bit c_bit_en = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic [3:0]         data_in;
    logic               data_vld;
    logic               clr_cnt;
    logic               locked;
    logic               err_pulse;
    logic [c_err_w-1:0] err_cnt;
    logic [c_err_w-1:0] bit_err_cnt;

    int checks   = 0;
    int failures = 0;

    prbs4_checker #(
        .LOCK_CNT (4),
        .LOSS_CNT (3),
        .ERR_W    (c_err_w)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .data_vld    (data_vld),
        .clr_cnt     (clr_cnt),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_cnt     (err_cnt),
        .bit_err_cnt (bit_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [3:0] data;
        logic       clr;
        logic       exp_locked;
        logic       exp_pulse;
        logic [3:0] exp_cnt;
        logic [3:0] exp_bit;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [3:0] f_next(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[0]};
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic e_locked,
                             input logic e_pulse, input logic [3:0] e_cnt,
                             input logic [3:0] e_bit);
        chk({tag, ".locked"},    idx, 16'(locked),      16'(e_locked));
        chk({tag, ".err_pulse"}, idx, 16'(err_pulse),   16'(e_pulse));
        chk({tag, ".err_cnt"},   idx, 16'(err_cnt),     16'(e_cnt));
        chk({tag, ".bit_cnt"},   idx, 16'(bit_err_cnt), c_bit_en ? 16'(e_bit) : 16'd0);
    endtask

    // Drive on the falling edge, sample just after the following rising edge.
    task automatic step(input logic vld, input logic [3:0] data, input logic clr);
        @(negedge clk);
        data_vld = vld;
        data_in  = data;
        clr_cnt  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic [3:0] d, input logic c, input logic l,
                       input logic p, input logic [3:0] n, input logic [3:0] b);
        vec_t t;
        t.vld = v; t.data = d; t.clr = c; t.exp_locked = l;
        t.exp_pulse = p; t.exp_cnt = n; t.exp_bit = b;
        vecs.push_back(t);
    endtask

    logic [3:0] m_exp;
    logic [3:0] wrong;
    int         sat;

    initial begin
        rst_n    = 1'b0;
        data_vld = 1'b0;
        data_in  = 4'd0;
        clr_cnt  = 1'b0;

        //   vld data   clr  locked pulse cnt bit
        add(0, 4'h9, 0, 0, 0, 0, 0);  // gap in SEARCH
        add(1, 4'h0, 0, 0, 0, 0, 0);  // illegal seed ignored
        add(1, 4'h9, 0, 0, 0, 0, 0);  // seed
        add(1, 4'h2, 0, 0, 0, 0, 0);
        add(1, 4'h4, 0, 0, 0, 0, 0);
        add(1, 4'h8, 0, 0, 0, 0, 0);
        add(1, 4'h1, 0, 1, 0, 0, 0);  // 4th match -> locked
        add(1, 4'h3, 0, 1, 0, 0, 0);
        add(0, 4'h0, 0, 1, 0, 0, 0);  // gap while locked
        add(1, 4'h5, 0, 1, 1, 1, 1);  // expected 0111, one bit wrong
        add(1, 4'hF, 0, 1, 0, 1, 1);
        add(1, 4'hE, 0, 1, 0, 1, 1);
        add(0, 4'h0, 0, 1, 0, 1, 1);  // gap: counters hold
        add(1, 4'hD, 0, 1, 0, 1, 1);
        add(1, 4'hA, 0, 1, 0, 1, 1);
        add(1, 4'h4, 1, 1, 1, 0, 0);  // expected 0101: clear beats count, pulse stays
        add(1, 4'hB, 0, 1, 0, 0, 0);
        add(1, 4'h0, 0, 1, 1, 1, 2);  // expected 0110
        add(1, 4'h0, 0, 1, 1, 2, 4);  // expected 1100
        add(1, 4'h0, 0, 0, 1, 3, 6);  // expected 1001, 3rd error -> lose lock
        add(1, 4'hD, 0, 0, 0, 3, 6);  // re-seed
        add(1, 4'hA, 0, 0, 0, 3, 6);
        add(1, 4'h5, 0, 0, 0, 3, 6);
        add(1, 4'hB, 0, 0, 0, 3, 6);
        add(1, 4'h6, 0, 1, 0, 3, 6);  // relock
        add(1, 4'hC, 0, 1, 0, 3, 6);
        add(0, 4'h0, 1, 1, 0, 0, 0);  // clear alone

        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].vld, vecs[i].data, vecs[i].clr);
            check_all("vec", i, vecs[i].exp_locked, vecs[i].exp_pulse,
                      vecs[i].exp_cnt, vecs[i].exp_bit);
        end

        // Saturation: 20 isolated single-bit errors, each followed by a good word.
        m_exp = 4'h9;
        for (int k = 0; k < 20; k++) begin
            wrong = m_exp ^ 4'b0001;
            step(1'b1, wrong, 1'b0);
            sat = (k + 1 > 15) ? 15 : k + 1;
            check_all("sat_err", k, 1, 1, 4'(sat), 4'(sat));
            m_exp = f_next(m_exp);
            step(1'b1, m_exp, 1'b0);
            chk("sat_good.err_pulse", k, 16'(err_pulse), 16'd0);
            m_exp = f_next(m_exp);
        end
        check_all("sat_end", 0, 1, 0, 15, 15);

        // Asynchronous reset mid-stream, away from any clock edge.
        @(negedge clk);
        data_vld = 1'b1;
        data_in  = m_exp ^ 4'b0011;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_all("rst_hold", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh acquisition after reset: seed plus three matches is not enough.
        step(1'b1, 4'h9, 1'b0);
        step(1'b1, 4'h2, 1'b0);
        step(1'b1, 4'h4, 1'b0);
        step(1'b1, 4'h8, 1'b0);
        check_all("reacq3", 0, 0, 0, 0, 0);
        step(1'b1, 4'h1, 1'b0);
        check_all("reacq4", 0, 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
